// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Single-outstanding instruction fetch with redirect/discard and a
//            one-entry {pc, instr} output buffer. Define FETCH_ADEL_CHECK_EN to
//            turn misaligned PCs into address-error entries.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel,
    input  logic        out_ready
);

    localparam logic [1:0] ST_REQ          = 2'd0;
    localparam logic [1:0] ST_WAIT         = 2'd1;
    localparam logic [1:0] ST_WAIT_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic        w_misaligned;
    logic        w_buf_free;
    logic        w_req_fire;
    logic        w_resp_wr;
    logic        w_adel_wr;

    assign w_buf_free = !out_valid_q || out_ready;
    assign ireq_valid = (state_q == ST_REQ) && w_buf_free && !w_misaligned;
    assign w_req_fire = ireq_valid && ireq_ready;
    assign w_resp_wr  = (state_q == ST_WAIT) && iresp_valid && !redirect_valid;

`ifdef FETCH_ADEL_CHECK_EN
    logic adel_q, adel_d;
    logic adel_done_q, adel_done_d;

    assign w_misaligned = (pc_q[1:0] != 2'b00);
    assign ireq_addr    = pc_q;
    // adel_done_q keeps a drained error entry from being re-posted until a redirect
    assign w_adel_wr    = (state_q == ST_REQ) && w_misaligned && w_buf_free
                          && !adel_done_q && !redirect_valid;
    assign out_adel     = adel_q;

    always_comb begin
        adel_d      = adel_q;
        adel_done_d = adel_done_q;
        if (w_resp_wr || w_adel_wr) begin
            adel_d = w_adel_wr;
        end
        if (redirect_valid) begin
            adel_done_d = 1'b0;
        end else if (w_adel_wr) begin
            adel_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adel_q      <= 1'b0;
            adel_done_q <= 1'b0;
        end else begin
            adel_q      <= adel_d;
            adel_done_q <= adel_done_d;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign ireq_addr    = {pc_q[31:2], 2'b00};
    assign w_adel_wr    = 1'b0;
    assign out_adel     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;

        case (state_q)
            ST_REQ: begin
                if (w_req_fire) begin
                    state_d = redirect_valid ? ST_WAIT_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iresp_valid) begin
                    state_d = ST_REQ;
                end else if (redirect_valid) begin
                    state_d = ST_WAIT_DISCARD;
                end
            end
            ST_WAIT_DISCARD: begin
                if (iresp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (w_resp_wr) begin
            pc_d = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        if (w_resp_wr || w_adel_wr) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = w_resp_wr ? iresp_data : 32'd0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A flush beats both a buffer write and a same-cycle drain
        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_instr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end that owns the architectural PC, issues one instruction-bus read at a time, and delivers `{pc, instr}` pairs to the fetch stage through a one-entry output buffer with valid/ready handshake. It sits directly upstream of the fetch stage, which computes pc+4 and writes the decode register. It takes redirects (branch/jump/exception targets) from PC select and discards any bus response that a redirect has made stale.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: PC loaded on reset.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ireq_valid` out 1: read request to instruction bus.
- `ireq_addr` out 32: request address, equal to current PC.
- `ireq_ready` in 1: bus accepted the address this cycle.
- `iresp_valid` in 1: read data returned this cycle. Cannot be back-pressured.
- `iresp_data` in 32: returned instruction word.
- `redirect_valid` in 1: single-cycle redirect request.
- `redirect_pc` in 32: redirect target.
- `out_valid` out 1: output buffer holds an instruction.
- `out_pc` out 32: PC of the buffered instruction.
- `out_instr` out 32: buffered instruction word.
- `out_adel` out 1: buffered entry is an address-error fetch. `out_instr` is 0 when set.
- `out_ready` in 1: fetch stage consumes the buffer this cycle.

## Operation
- The state machine has three states:
  - REQ: ready to issue.
  - WAIT: one request outstanding, response wanted.
  - WAIT_DISCARD: one request outstanding, response stale.
- REQ:
  - `ireq_valid` = (!out_valid || out_ready) && !misaligned. `misaligned` is defined under Configuration.
  - On `ireq_valid && ireq_ready`: go to WAIT.
  - With a redirect in the same cycle: go to WAIT_DISCARD instead.
- WAIT:
  - On `iresp_valid`: write the buffer with {pc, iresp_data}, set out_valid, PC <= PC+4, go to REQ.
  - With a redirect in the same cycle: drop the response, go to REQ.
- WAIT_DISCARD:
  - On `iresp_valid`: drop the response, go to REQ.
  - `iresp_valid` is ignored in REQ.
- Redirect, in any state:
  - PC <= redirect_pc and out_valid <= 0. The flush wins over a same-cycle `out_ready`.
  - A redirect in WAIT moves the state to WAIT_DISCARD.
  - A redirect has priority over the PC+4 update and over a buffer write.
- Buffer drain: `out_valid && out_ready` with no same-cycle write clears out_valid. A simultaneous drain and write leaves out_valid=1 with the new contents.
- At most one request outstanding; a request is never issued while a discard is pending.
- Arithmetic: PC+4 is modulo 2^32; 32'hffff_fffc wraps to 0.

## Timing
- Reset values:
  - PC = RESET_PC, state REQ.
  - out_valid=0, out_pc=0, out_instr=0, out_adel=0.
  - `ireq_valid`=1 in the first cycle after reset deasserts.
- Reset mid-transaction abandons the outstanding request. The instruction bus is reset by the same signal, so no late response follows.
- `ireq_valid` and `ireq_addr` are combinational from registered state plus `out_valid`/`out_ready`. They do not depend on `iresp_*` or `redirect_*`.
- Latency from response to output: `iresp_valid` in cycle N gives `out_valid`=1 in cycle N+1. The next request can assert in N+1.
- Best-case throughput is one instruction per 2 cycles with a 1-cycle-latency bus.
- Redirect in cycle N: `ireq_addr` = redirect_pc from N+1, unless a discard is pending.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - `misaligned` = PC[1:0]!=0.
  - In REQ with misaligned PC and buffer free, no bus request is made.
  - The buffer is written with {pc, 0}, out_adel=1, PC holds, state stays REQ.
  - This repeats only after a redirect, so a drain does not refill it.
- `FETCH_ADEL_CHECK_EN` undefined:
  - `misaligned` = 0 and `out_adel` is tied 0.
  - `ireq_addr` = {PC[31:2], 2'b00}.

## Test plan
- Reset, bus with 1-cycle latency, out_ready=1 → out_pc sequence bfc0_0000, bfc0_0004, bfc0_0008, one entry every 2 cycles, out_instr matching memory.
- out_ready=0 after first capture → out_valid stays 1 with stable contents, `ireq_valid`=0. Set out_ready=1 → request for bfc0_0004 issues in that same cycle.
- Redirect to 8000_0100 while in WAIT, response returns 3 cycles later → that response never appears on out. The next `ireq_addr` is 8000_0100.
- Redirect in the same cycle as `iresp_valid` (WAIT) → response dropped, out_valid=0, next request is to redirect_pc. The same redirect in the accept cycle of a REQ → WAIT_DISCARD path.
- PC=ffff_fffc fetch → next `ireq_addr` is 0000_0000.
- With `FETCH_ADEL_CHECK_EN`, redirect to 8000_0002 → no bus request, out_valid=1, out_adel=1, out_pc=8000_0002, out_instr=0. Redirect to 8000_0004 → normal fetch resumes.
